// File: rtl/vga_scanout_pkg.sv
// Shared constants, colour names and the framebuffer address helper for the VGA scanout block.
// The optional colour-bar generator is enabled by defining SCANOUT_TEST_PATTERN_EN.
package vga_scanout_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int SCALE_SHIFT = 2;
    localparam int FB_WIDTH    = 160;
    localparam int FB_HEIGHT   = 120;
    localparam int FB_ADDR_W   = 15;
    localparam int BAR_WIDTH   = 80;

    typedef enum logic [2:0] {
        BLACK  = 3'b000,
        BLUE   = 3'b001,
        GREEN  = 3'b010,
        YELLOW = 3'b110,
        RED    = 3'b100,
        WHITE  = 3'b111
    } colour_t;

    // fy*160 + fx, built from shifts so no multiplier is needed.
    function automatic logic [FB_ADDR_W-1:0] fb_address(input logic [9:0] hcount,
                                                         input logic [9:0] vcount);
        logic [FB_ADDR_W-1:0] fx;
        logic [FB_ADDR_W-1:0] fy;
        fx = FB_ADDR_W'(hcount >> SCALE_SHIFT);
        fy = FB_ADDR_W'(vcount >> SCALE_SHIFT);
        return (fy << 7) + (fy << 5) + fx;
    endfunction

    // Eight vertical bars, each BAR_WIDTH pixels wide, numbered left to right.
    function automatic logic [2:0] bar_colour(input logic [9:0] hcount);
        logic [2:0] bar;
        bar = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (hcount >= 10'(i * BAR_WIDTH)) bar = 3'(i);
        end
        return bar;
    endfunction

endpackage

// File: rtl/vga_scanout_timing.sv
// Pixel-enable phase, horizontal/vertical counters and raw (undelayed) sync/active flags.
module vga_timing_gen
    import vga_scanout_pkg::*;
#(
    parameter int H_ACTIVE = vga_scanout_pkg::H_VISIBLE,
    parameter int H_FP     = vga_scanout_pkg::H_FRONT,
    parameter int H_SW     = vga_scanout_pkg::H_SYNC,
    parameter int H_BP     = vga_scanout_pkg::H_BACK,
    parameter int V_ACTIVE = vga_scanout_pkg::V_VISIBLE,
    parameter int V_FP     = vga_scanout_pkg::V_FRONT,
    parameter int V_SW     = vga_scanout_pkg::V_SYNC,
    parameter int V_BP     = vga_scanout_pkg::V_BACK
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    output logic       pix_en,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SW + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SW + V_BP;

    logic h_last;
    logic v_last;

    assign h_last = (hcount == 10'(H_TOTAL - 1));
    assign v_last = (vcount == 10'(V_TOTAL - 1));

    always_ff @(posedge CLOCK_50) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values,
        // independent of statement order inside and across always_ff blocks.
        if (reset) begin
            pix_en      <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            frame_start <= 1'b0;
        end else begin
            pix_en      <= ~pix_en;
            frame_start <= pix_en && h_last && v_last;
            if (pix_en) begin
                if (h_last) begin
                    hcount <= '0;
                    vcount <= v_last ? '0 : vcount + 10'd1;
                end else begin
                    hcount <= hcount + 10'd1;
                end
            end
        end
    end

    assign hsync  = !((hcount >= 10'(H_ACTIVE + H_FP)) && (hcount < 10'(H_ACTIVE + H_FP + H_SW)));
    assign vsync  = !((vcount >= 10'(V_ACTIVE + V_FP)) && (vcount < 10'(V_ACTIVE + V_FP + V_SW)));
    assign active = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer scanout: address generation, one-pixel alignment pipeline and colour expansion.
// Defining SCANOUT_TEST_PATTERN_EN adds a test_mode input that selects colour bars.
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int H_ACTIVE = vga_scanout_pkg::H_VISIBLE,
    parameter int H_FP     = vga_scanout_pkg::H_FRONT,
    parameter int H_SW     = vga_scanout_pkg::H_SYNC,
    parameter int H_BP     = vga_scanout_pkg::H_BACK,
    parameter int V_ACTIVE = vga_scanout_pkg::V_VISIBLE,
    parameter int V_FP     = vga_scanout_pkg::V_FRONT,
    parameter int V_SW     = vga_scanout_pkg::V_SYNC,
    parameter int V_BP     = vga_scanout_pkg::V_BACK
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    output logic [FB_ADDR_W-1:0] fb_addr,
    input  logic [2:0]           fb_q,
`ifdef SCANOUT_TEST_PATTERN_EN
    input  logic                 test_mode,
`endif
    output logic                 frame_start,
    output logic [9:0]           VGA_R,
    output logic [9:0]           VGA_G,
    output logic [9:0]           VGA_B,
    output logic                 VGA_HS,
    output logic                 VGA_VS,
    output logic                 VGA_BLANK,
    output logic                 VGA_SYNC,
    output logic                 VGA_CLK
);

    logic       pix_en;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hsync;
    logic       vsync;
    logic       active;
    logic [2:0] colour;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SW     (H_SW),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SW     (V_SW),
        .V_BP     (V_BP)
    ) u_timing (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .pix_en      (pix_en),
        .hcount      (hcount),
        .vcount      (vcount),
        .hsync       (hsync),
        .vsync       (vsync),
        .active      (active),
        .frame_start (frame_start)
    );

    // Address is held at 0 outside the visible area so it never leaves the framebuffer.
    assign fb_addr = active ? fb_address(hcount, vcount) : '0;

    always_comb begin
        // NOTE: default first so every path assigns colour and no latch is inferred.
        colour = BLACK;
        if (active) begin
`ifdef SCANOUT_TEST_PATTERN_EN
            colour = test_mode ? bar_colour(hcount) : fb_q;
`else
            colour = fb_q;
`endif
        end
    end

    // fb_q arrives one clock after fb_addr, i.e. in the pix_en=1 clock of the same pixel,
    // so capturing it with the syncs of the same counters keeps data and syncs aligned.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
            VGA_HS    <= 1'b1;
            VGA_VS    <= 1'b1;
            VGA_BLANK <= 1'b0;
        end else if (pix_en) begin
            VGA_R     <= {10{colour[2]}};
            VGA_G     <= {10{colour[1]}};
            VGA_B     <= {10{colour[0]}};
            VGA_HS    <= hsync;
            VGA_VS    <= vsync;
            VGA_BLANK <= active;
        end
    end

    assign VGA_SYNC = 1'b1;
    assign VGA_CLK  = pix_en;

endmodule
